// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared state encoding and default width for the parity serializer
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int DATA_W_DEFAULT = 8;

endpackage

// File: rtl/even_parity_serializer.sv
// rtl/even_parity_serializer.sv - LSB-first word serializer appending an even-parity bit
module even_parity_serializer
  import parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              tx_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_last,
  output logic              busy
);

  localparam int            CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W);

  state_t            state, state_d;
  logic [DATA_W-1:0] sr, sr_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              par, par_d;
  logic              dout_d, dv_d, fl_d, busy_d;
  logic              accept;

  assign load_ready = !rst && (state == IDLE || (state == PARITY && tx_en));
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      par        <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      sr         <= sr_d;
      cnt        <= cnt_d;
      par        <= par_d;
      dout       <= dout_d;
      dout_valid <= dv_d;
      frame_last <= fl_d;
      busy       <= busy_d;
    end
  end

  // cnt counts data bits already placed on dout; the accepting edge presents bit 0 itself
  always_comb begin
    state_d = state;
    sr_d    = sr;
    cnt_d   = cnt;
    par_d   = par;
    dout_d  = dout;
    dv_d    = 1'b0;
    fl_d    = 1'b0;
    busy_d  = busy;

    case (state)
      IDLE: ;
      SHIFT: begin
        if (tx_en) begin
          dv_d = 1'b1;
          if (cnt == LAST_CNT) begin
            dout_d  = par;
            fl_d    = 1'b1;
            state_d = PARITY;
          end else begin
            dout_d = sr[0];
            par_d  = par ^ sr[0];
            sr_d   = sr >> 1;
            cnt_d  = cnt + CW'(1);
          end
        end
      end
      PARITY: begin
        if (tx_en) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the parity cycle overrides the return to IDLE for gapless streaming
    if (accept) begin
      state_d = SHIFT;
      sr_d    = load_data >> 1;
      cnt_d   = CW'(1);
      par_d   = load_data[0];
      dout_d  = load_data[0];
      dv_d    = 1'b1;
      fl_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_even_parity_serializer.sv
// tb/tb_even_parity_serializer.sv - scoreboard bench for even_parity_serializer
module tb_even_parity_serializer;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       tx_en;
  logic       dout;
  logic       dout_valid;
  logic       frame_last;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] e;

  even_parity_serializer #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .tx_en      (tx_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_last (frame_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {frame_last, dout} per valid cycle: data LSB-first, then even parity
  task automatic push_frame(input logic [7:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, w[i]});
    exp_q.push_back({1'b1, ^w});
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; tx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dout, dout_valid, frame_last, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b required 0000", {dout, dout_valid, frame_last, busy});
    end
    checks++;
    if (load_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b required 0", load_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b required 1", load_ready);
    end
    exp_q.delete();
  endtask

  task automatic test_single_frame(input logic [7:0] w);
    int vcnt = 0;
    load_valid = 1'b1; load_data = w; tx_en = 1'b1;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL frame_ready_%h: got %b required 1", w, load_ready);
    end
    if (load_valid && load_ready) push_frame(w);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      checks++;
      if (dout_valid === 1'b1) begin
        vcnt++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL frame_%h_extra: dout_valid=1 with nothing expected", w);
        end else begin
          e = exp_q.pop_front();
          if ({frame_last, dout} !== e) begin
            errors++; $display("FAIL frame_%h_bit%0d: got last/dout %b required %b", w, c, {frame_last, dout}, e);
          end
        end
      end else if (frame_last !== 1'b0) begin
        errors++; $display("FAIL frame_%h_last_idle: got %b required 0", w, frame_last);
      end
      if (c == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL frame_%h_busy_rise: got %b required 1", w, busy);
        end
      end
      if (c == 9) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL frame_%h_busy_fall: got %b required 0", w, busy);
        end
      end
      load_valid = 1'b0;
    end
    checks++;
    if (vcnt != 9 || exp_q.size() != 0) begin
      errors++; $display("FAIL frame_%h_len: got %0d valid, %0d pending required 9, 0", w, vcnt, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int vcnt = 0;
    int gaps = 0;
    int busy_drops = 0;
    load_valid = 1'b1; load_data = 8'h6D; tx_en = 1'b1;
    #1;
    if (load_valid && load_ready) push_frame(load_data);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (dout_valid === 1'b1) begin
        vcnt++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: dout_valid=1 with nothing expected");
        end else begin
          e = exp_q.pop_front();
          if ({frame_last, dout} !== e) begin
            errors++; $display("FAIL b2b_bit%0d: got last/dout %b required %b", c, {frame_last, dout}, e);
          end
        end
      end else if (frame_last !== 1'b0) begin
        errors++; $display("FAIL b2b_last_idle: got %b required 0", frame_last);
      end
      if (c < 18 && dout_valid !== 1'b1) gaps++;
      if (c < 18 && busy !== 1'b1) busy_drops++;
      if (c == 8) load_data = 8'h01;
      if (c >= 9) load_valid = 1'b0;
      #1;
      if (c == 3) begin
        checks++;
        if (load_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_ready_shift: got %b required 0", load_ready);
        end
      end
      if (c == 8) begin
        checks++;
        if (load_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_parity: got %b required 1", load_ready);
        end
      end
      if (load_valid && load_ready) push_frame(load_data);
    end
    checks++;
    if (vcnt != 18 || gaps != 0 || busy_drops != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_stream: got valid=%0d gaps=%0d busy_drops=%0d pending=%0d required 18 0 0 0", vcnt, gaps, busy_drops, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int vcnt = 0;
    load_valid = 1'b1; load_data = 8'hA5; tx_en = 1'b1;
    #1;
    if (load_valid && load_ready) push_frame(load_data);
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      checks++;
      if (dout_valid === 1'b1) begin
        vcnt++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra: dout_valid=1 with nothing expected");
        end else begin
          e = exp_q.pop_front();
          if ({frame_last, dout} !== e) begin
            errors++; $display("FAIL stall_bit%0d: got last/dout %b required %b", c, {frame_last, dout}, e);
          end
        end
      end else if (frame_last !== 1'b0) begin
        errors++; $display("FAIL stall_last_idle: got %b required 0", frame_last);
      end
      if (c >= 3 && c <= 5) begin
        checks++;
        if (dout_valid !== 1'b0 || dout !== 1'b1 || busy !== 1'b1) begin
          errors++; $display("FAIL stall_hold%0d: got valid/dout/busy %b required 011", c, {dout_valid, dout, busy});
        end
      end
      load_valid = 1'b0;
      tx_en = !(c >= 2 && c <= 4);
      #1;
      if (c == 3) begin
        checks++;
        if (load_ready !== 1'b0) begin
          errors++; $display("FAIL stall_ready: got %b required 0", load_ready);
        end
      end
    end
    checks++;
    if (vcnt != 9 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_len: got %0d valid, %0d pending required 9, 0", vcnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int vcnt = 0;
    load_valid = 1'b1; load_data = 8'h6D; tx_en = 1'b1;
    #1;
    if (load_valid && load_ready) push_frame(load_data);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (dout_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("FAIL abort_pre%0d: got valid %b required 1", c, dout_valid);
      end else begin
        e = exp_q.pop_front();
        if ({frame_last, dout} !== e) begin
          errors++; $display("FAIL abort_bit%0d: got last/dout %b required %b", c, {frame_last, dout}, e);
        end
      end
      load_valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    checks++;
    if ({dout, dout_valid, frame_last, busy, load_ready} !== 5'b00000) begin
      errors++; $display("FAIL abort_outputs: got %b required 00000", {dout, dout_valid, frame_last, busy, load_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready_release: got %b required 1", load_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_resume: got valid/busy %b required 00", {dout_valid, busy});
    end
    load_valid = 1'b1; load_data = 8'h03;
    #1;
    if (load_valid && load_ready) push_frame(load_data);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      checks++;
      if (dout_valid === 1'b1) begin
        vcnt++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL fresh_extra: dout_valid=1 with nothing expected");
        end else begin
          e = exp_q.pop_front();
          if ({frame_last, dout} !== e) begin
            errors++; $display("FAIL fresh_bit%0d: got last/dout %b required %b", c, {frame_last, dout}, e);
          end
        end
      end
      load_valid = 1'b0;
    end
    checks++;
    if (vcnt != 9 || exp_q.size() != 0) begin
      errors++; $display("FAIL fresh_len: got %0d valid, %0d pending required 9, 0", vcnt, exp_q.size());
    end
  endtask

  task automatic test_loopback();
    int   frames = 0;
    int   sent = 0;
    logic det = 1'b0;
    logic acc;
    load_valid = 1'b1; load_data = 8'($urandom); tx_en = 1'b1;
    #1;
    acc = load_valid && load_ready;
    if (acc) push_frame(load_data);
    for (int cyc = 0; cyc < 4000 && frames < 100; cyc++) begin
      @(posedge clk); #1;
      if (dout_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL loop_extra: dout_valid=1 with nothing expected");
        end else begin
          e = exp_q.pop_front();
          if ({frame_last, dout} !== e) begin
            errors++; $display("FAIL loop_bit: frame %0d got last/dout %b required %b", frames, {frame_last, dout}, e);
          end
        end
        det = det ^ dout;
        if (frame_last === 1'b1) begin
          checks++;
          if (det !== 1'b0) begin
            errors++; $display("FAIL loop_even: frame %0d got odd ones required even", frames);
          end
          det = 1'b0;
          frames++;
        end
      end
      tx_en = ($urandom_range(0, 3) != 0);
      if (acc) begin
        sent++;
        if (sent < 100) load_data = 8'($urandom);
        else load_valid = 1'b0;
      end
      #1;
      acc = load_valid && load_ready;
      if (acc) push_frame(load_data);
    end
    checks++;
    if (frames != 100 || exp_q.size() != 0) begin
      errors++; $display("FAIL loop_count: got %0d frames, %0d pending required 100, 0", frames, exp_q.size());
    end
    load_valid = 1'b0; tx_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single_frame(8'h6D);
    test_single_frame(8'h00);
    test_single_frame(8'hFF);
    test_back_to_back();
    test_stall();
    test_reset_mid_frame();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
